// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data memory: sizes, aligns and extends
// byte/half/word accesses and splits word-crossing accesses into two words.
module load_store_unit #(
  parameter int DATA_BITS = 16,
  parameter bit SYNC_READ = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_error,
  output logic [DATA_BITS-3:0] mem_address,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_data,
  output logic                 mem_wren,
  input  logic [31:0]          mem_q
);

  localparam int AW = DATA_BITS - 2;

  typedef enum logic [2:0] {IDLE, ACC_A, WAIT_A, ACC_B, WAIT_B, DONE} state_t;

  state_t      state;
  logic        wr_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic        split_r;
  logic [3:0]  mask_hi_r;
  logic [31:0] wd_hi_r;
  logic [AW-1:0] word_a_r;
  logic [31:0] qa_r;

  function automatic logic f3_ok(input logic wr, input logic [2:0] f3);
    if (wr) return (f3 <= 3'd2);
    else    return (f3[1:0] != 2'b11) && (f3 != 3'd6);
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] base;
    case (f3[1:0])
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  // Shift the two captured words down to the access offset, then extend.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] qb, input logic [31:0] qa);
    logic [31:0]        lo;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] ext;
    lo = 32'({qb, qa} >> {off, 3'b000});
    sb = lo[7:0];
    sh = lo[15:0];
    case (f3)
      3'd0:    ext = sb;
      3'd1:    ext = sh;
      3'd2:    ext = lo;
      3'd4:    ext = {24'b0, lo[7:0]};
      3'd5:    ext = {16'b0, lo[15:0]};
      default: ext = '0;
    endcase
    return ext;
  endfunction

  logic [7:0]    in_mask;
  logic [63:0]   in_wd64;
  logic [AW-1:0] word_b;
  logic          a_waits;
  logic          b_waits;

  assign in_mask = lane_mask(req_funct3, req_addr[1:0]);
  assign in_wd64 = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
  assign word_b  = word_a_r + AW'(1);
  assign a_waits = (state == ACC_A) && SYNC_READ && !wr_r;
  assign b_waits = (state == ACC_B) && SYNC_READ && !wr_r;

  generate
    if (DATA_BITS < 32) begin : g_unused
      logic unused_addr;
      assign unused_addr = ^req_addr[31:DATA_BITS];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_error  <= 1'b0;
      mem_wren    <= 1'b0;
      mem_byteena <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      wr_r        <= 1'b0;
      f3_r        <= '0;
      off_r       <= '0;
      split_r     <= 1'b0;
      mask_hi_r   <= '0;
      wd_hi_r     <= '0;
      word_a_r    <= '0;
      qa_r        <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            wr_r      <= req_write;
            f3_r      <= req_funct3;
            off_r     <= req_addr[1:0];
            split_r   <= |in_mask[7:4];
            mask_hi_r <= in_mask[7:4];
            wd_hi_r   <= in_wd64[63:32];
            word_a_r  <= req_addr[DATA_BITS-1:2];
            if (!f3_ok(req_write, req_funct3)) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state       <= ACC_A;
              mem_address <= req_addr[DATA_BITS-1:2];
              mem_byteena <= in_mask[3:0];
              mem_data    <= in_wd64[31:0];
              mem_wren    <= req_write;
            end
          end
        end
        // First word: either wait for synchronous read data or capture it now.
        ACC_A, WAIT_A: begin
          if (a_waits) begin
            state    <= WAIT_A;
            mem_wren <= 1'b0;
          end else begin
            qa_r <= mem_q;
            if (split_r) begin
              state       <= ACC_B;
              mem_address <= word_b;
              mem_byteena <= mask_hi_r;
              mem_data    <= wd_hi_r;
              mem_wren    <= wr_r;
            end else begin
              state       <= DONE;
              mem_wren    <= 1'b0;
              mem_byteena <= '0;
              resp_valid  <= 1'b1;
              resp_error  <= 1'b0;
              resp_rdata  <= wr_r ? 32'b0 : load_value(f3_r, off_r, 32'b0, mem_q);
            end
          end
        end
        ACC_B, WAIT_B: begin
          if (b_waits) begin
            state    <= WAIT_B;
            mem_wren <= 1'b0;
          end else begin
            state       <= DONE;
            mem_wren    <= 1'b0;
            mem_byteena <= '0;
            resp_valid  <= 1'b1;
            resp_error  <= 1'b0;
            resp_rdata  <= wr_r ? 32'b0 : load_value(f3_r, off_r, mem_q, qa_r);
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with combinational memory
// read and one with registered read, each backed by a small memory model.
module tb_load_store_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        valid0, valid1, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        ready0, rv0, re0, wren0;
  logic [31:0] rd0, data0, q0;
  logic [13:0] addr0;
  logic [3:0]  be0;
  logic        ready1, rv1, re1, wren1;
  logic [31:0] rd1, data1, q1;
  logic [13:0] addr1;
  logic [3:0]  be1;

  logic [31:0] mem0 [0:16383];
  logic [31:0] mem1 [0:16383];

  load_store_unit #(.DATA_BITS(16), .SYNC_READ(1'b0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(valid0), .req_ready(ready0),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_rdata(rd0), .resp_error(re0),
    .mem_address(addr0), .mem_byteena(be0), .mem_data(data0), .mem_wren(wren0),
    .mem_q(q0));

  load_store_unit #(.DATA_BITS(16), .SYNC_READ(1'b1)) dut1 (
    .clock(clock), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1), .resp_error(re1),
    .mem_address(addr1), .mem_byteena(be1), .mem_data(data1), .mem_wren(wren1),
    .mem_q(q1));

  assign q0 = mem0[addr0];

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (wren0 && be0[i]) mem0[addr0][8*i +: 8] <= data0[8*i +: 8];
      if (wren1 && be1[i]) mem1[addr1][8*i +: 8] <= data1[8*i +: 8];
    end
    q1 <= mem1[addr1];
  end

  int errors = 0;
  int checks = 0;

  int          lat;
  logic [31:0] r_rdata;
  logic [31:0] r_err;
  logic [31:0] t_addr [1:12];
  logic [31:0] t_be   [1:12];
  logic [31:0] t_data [1:12];
  logic [31:0] t_wren [1:12];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit sel, input bit w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    lat = 0;
    r_rdata = 'x;
    r_err = 'x;
    @(negedge clock);
    check("req_ready_idle", 32'(sel ? ready1 : ready0), 32'd1);
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clock);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (i == 1) begin
        valid0 = 1'b0; valid1 = 1'b0;
        req_write = ~w; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      t_addr[i] = 32'(sel ? addr1 : addr0);
      t_be[i]   = 32'(sel ? be1 : be0);
      t_data[i] = sel ? data1 : data0;
      t_wren[i] = 32'(sel ? wren1 : wren0);
      if (sel ? rv1 : rv0) begin
        got = 1'b1;
        lat = i;
        r_rdata = sel ? rd1 : rd0;
        r_err = 32'(sel ? re1 : re0);
        break;
      end
    end
    check("resp_seen", 32'(got), 32'd1);
    if (got) begin
      @(negedge clock);
      check("resp_one_cycle", 32'(sel ? rv1 : rv0), 32'd0);
    end
  endtask

  task automatic load_expect(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp);
    do_req(1'b0, 1'b0, f3, a, 32'h0);
    check(tag, r_rdata, exp);
    check({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid0 = 1'b0; valid1 = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_resp_valid", 32'(rv0), 32'd0);
    check("rst_rdata", rd0, 32'd0);
    check("rst_error", 32'(re0), 32'd0);
    check("rst_wren", 32'(wren0), 32'd0);
    check("rst_byteena", 32'(be0), 32'd0);
    check("rst_address", 32'(addr0), 32'd0);
    check("rst_data", data0, 32'd0);
    reset = 1'b0;

    // Aligned word store then load
    do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    check("sw_addr", t_addr[1], 32'd4);
    check("sw_be", t_be[1], 32'hF);
    check("sw_wren", t_wren[1], 32'd1);
    check("sw_data", t_data[1], 32'hDEADBEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_rdata", r_rdata, 32'd0);
    check("sw_err", r_err, 32'd0);
    load_expect("lw_10", 3'd2, 32'h10, 32'hDEADBEEF);
    check("lw_wren", t_wren[1], 32'd0);

    // Sub-word loads with sign/zero extension
    do_req(1'b0, 1'b1, 3'd2, 32'h8, 32'h80FF7F01);
    load_expect("lb_9", 3'd0, 32'h9, 32'h0000007F);
    load_expect("lb_b", 3'd0, 32'hB, 32'hFFFFFF80);
    load_expect("lbu_b", 3'd4, 32'hB, 32'h00000080);
    load_expect("lh_a", 3'd1, 32'hA, 32'hFFFF80FF);
    load_expect("lhu_a", 3'd5, 32'hA, 32'h000080FF);

    // Byte store into a cleared word
    do_req(1'b0, 1'b1, 3'd2, 32'hC, 32'h0);
    do_req(1'b0, 1'b1, 3'd0, 32'hD, 32'h123456AB);
    check("sb_be", t_be[1], 32'h2);
    check("sb_data", t_data[1], 32'h3456AB00);
    load_expect("lw_c", 3'd2, 32'hC, 32'h0000AB00);

    // Split word store and load across words 3/4
    do_req(1'b0, 1'b1, 3'd2, 32'hE, 32'hAABBCCDD);
    check("ssw_a_addr", t_addr[1], 32'd3);
    check("ssw_a_be", t_be[1], 32'hC);
    check("ssw_a_data", 32'(t_data[1][31:16]), 32'hCCDD);
    check("ssw_a_wren", t_wren[1], 32'd1);
    check("ssw_b_addr", t_addr[2], 32'd4);
    check("ssw_b_be", t_be[2], 32'h3);
    check("ssw_b_data", 32'(t_data[2][15:0]), 32'hAABB);
    check("ssw_b_wren", t_wren[2], 32'd1);
    check("ssw_lat", 32'(lat), 32'd3);
    do_req(1'b0, 1'b0, 3'd2, 32'hE, 32'h0);
    check("slw_rdata", r_rdata, 32'hAABBCCDD);
    check("slw_lat", 32'(lat), 32'd3);

    // Wrap from the top word to word 0
    do_req(1'b0, 1'b0, 3'd1, 32'hFFFF, 32'h0);
    check("wrap_a_addr", t_addr[1], 32'h3FFF);
    check("wrap_a_be", t_be[1], 32'h8);
    check("wrap_b_addr", t_addr[2], 32'h0);
    check("wrap_b_be", t_be[2], 32'h1);
    check("wrap_lat", 32'(lat), 32'd3);

    // Unsupported funct3
    do_req(1'b0, 1'b0, 3'd3, 32'h10, 32'h0);
    check("err_ld_flag", r_err, 32'd1);
    check("err_ld_rdata", r_rdata, 32'd0);
    check("err_ld_lat", 32'(lat), 32'd1);
    check("err_ld_be", t_be[1], 32'd0);
    do_req(1'b0, 1'b1, 3'd5, 32'h10, 32'h12345678);
    check("err_st_flag", r_err, 32'd1);
    check("err_st_wren", t_wren[1], 32'd0);
    check("err_st_lat", 32'(lat), 32'd1);

    // Registered-read memory
    do_req(1'b1, 1'b1, 3'd2, 32'h20, 32'h11223344);
    check("s1_sw_lat", 32'(lat), 32'd2);
    do_req(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
    check("s1_lw_rdata", r_rdata, 32'h11223344);
    check("s1_lw_lat", 32'(lat), 32'd3);
    do_req(1'b1, 1'b1, 3'd2, 32'hE, 32'hAABBCCDD);
    check("s1_ssw_lat", 32'(lat), 32'd3);
    do_req(1'b1, 1'b0, 3'd2, 32'hE, 32'h0);
    check("s1_slw_rdata", r_rdata, 32'hAABBCCDD);
    check("s1_slw_lat", 32'(lat), 32'd5);
    check("s1_wait_a_addr", t_addr[2], 32'd3);
    check("s1_wait_a_be", t_be[2], 32'hC);
    check("s1_b_addr", t_addr[3], 32'd4);
    check("s1_wait_b_be", t_be[4], 32'h3);
    check("s1_wait_b_wren", t_wren[4], 32'd0);

    // Reset during the second half of a split store
    @(negedge clock);
    req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1E; req_wdata = 32'h55667788;
    valid0 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid0 = 1'b0;
    check("rmid_a_addr", 32'(addr0), 32'd7);
    @(negedge clock);
    check("rmid_b_addr", 32'(addr0), 32'd8);
    check("rmid_b_wren", 32'(wren0), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rmid_wren_async", 32'(wren0), 32'd0);
    check("rmid_ready_async", 32'(ready0), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rmid_no_resp", 32'(rv0), 32'd0);
    end
    check("rmid_first_half", 32'(mem0[7][31:16]), 32'h7788);
    load_expect("post_rst_lw", 3'd2, 32'h10, 32'hDEADAABB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts one load/store request at a time from the core's memory stage and drives the word-wide data memory (word address, byte enables, write data, write enable, read data).
- Handles byte/half/word sizing, lane alignment and sign/zero extension.
- Splits accesses that cross a word boundary into two sequential word accesses.
- Sits between the core's execute/memory stage and data_memory.

Parameters:
- DATA_BITS, 16, byte-address width of the data memory window; mem_address is DATA_BITS-2 bits.
- SYNC_READ, 0, 0 = mem_q is valid in the same cycle as mem_address; 1 = mem_q is valid one cycle later.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: load 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; store 0 SB, 1 SH, 2 SW.
- req_addr  input  32  byte address; only bits [DATA_BITS-1:0] are used.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse for loads and stores.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_error  output  1  qualifies resp_valid; unsupported funct3.
- mem_address  output  DATA_BITS-2  word address.
- mem_byteena  output  4  byte-lane enables.
- mem_data  output  32  write data.
- mem_wren  output  1  write enable.
- mem_q  input  32  read data.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high, ports named clock and reset.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_wren=0, mem_byteena=0, mem_address=0, mem_data=0.
- Request capture: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. All request fields are registered on acceptance, so later input changes are ignored.
- Lane computation: n = 1/2/4 bytes from funct3[1:0]; o = addr[1:0]; mask8 = ((1<<n)-1)<<o over 8 lanes.
- Split rule: lanes [3:0] go to word A = addr[DATA_BITS-1:2]; lanes [7:4] go to word A+1. A+1 wraps modulo 2^(DATA_BITS-2). split = |mask8[7:4].
- Write data: wdata64 = wdata<<(8*o); word A gets wdata64[31:0] and word A+1 gets wdata64[63:32]. Bytes outside the size are masked off by byteena.
- Read data: r64 = {qB,qA}>>(8*o); take the low n bytes; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Invalid funct3: loads 3/6/7, stores 3..7. No memory access; DONE is entered directly with resp_error=1.
- FSM transitions:
  - IDLE: accept request -> ACC_A, or DONE if invalid.
  - ACC_A: mem_address=A, mem_byteena=mask8[3:0], mem_wren=req_write.
    - SYNC_READ=0: a load captures mem_q as qA this cycle.
    - SYNC_READ=1 load: -> WAIT_A, which holds address and byteena with wren=0 and captures qA.
    - Then -> ACC_B if split, else DONE.
  - ACC_B / WAIT_B: same as ACC_A / WAIT_A for word A+1, mask8[7:4], capturing qB. Then -> DONE.
  - DONE: resp_valid=1 for exactly one cycle with resp_rdata and resp_error registered; -> IDLE.
- Responses have no backpressure; the consumer must take them in the DONE cycle. The next request can be accepted the cycle after DONE.
- Idle memory outputs: outside ACC/WAIT states mem_wren=0 and mem_byteena=0. mem_wren is never asserted in WAIT states or for loads.
- Latency, in cycles from the acceptance edge to resp_valid: aligned = 2 (SYNC_READ=0) or 3 (SYNC_READ=1 load); split = 3 or 5; invalid = 1.
- Reset mid-operation: immediate return to IDLE with wren dropped. If the first half of a split store was already written, it stays written; no response is issued.

Test Plan:
- Aligned SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> cycle 1 after accept: mem_address=4, byteena=1111, wren=1; LW resp_rdata=0xDEADBEEF, resp_valid exactly 2 cycles after accept (SYNC_READ=0).
- Word 0x8 = 0x80FF7F01: LB 0x9 -> 0x0000007F; LB 0xB -> 0xFFFFFF80; LBU 0xB -> 0x00000080; LH 0xA -> 0xFFFF80FF; LHU 0xA -> 0x000080FF.
- SB 0x0D data 0x123456AB over word 0x0C = 0 -> byteena=0010, mem_data=0x3456AB00; the word then reads 0x0000AB00.
- Split SW addr 0x0E data 0xAABBCCDD -> word 3 written with byteena=1100, data[31:16]=0xCCDD; word 4 written with byteena=0011, data[15:0]=0xAABB; resp after 3 cycles. LW 0x0E then returns 0xAABBCCDD. Repeat with SYNC_READ=1: load latency is 5.
- Wrap: DATA_BITS=16, LH addr 0xFFFF -> accesses words 0x3FFF then 0x0000.
- Error and reset: LW with funct3=3 -> resp_error=1 after 1 cycle, mem_byteena stays 0. Assert reset during ACC_B of a split store -> mem_wren drops asynchronously, no resp_valid, req_ready=1 after reset.
